drp_reg_slave: RTL and testbench
================================

Name: drp_reg_slave

Overview:
- DRP-side register bank that sits directly downstream of axi2drp and terminates its M_DRP* master port.
- Accepts one DRP transaction at a time and answers each with a single-cycle S_DRPRDY pulse after a fixed, parameterised latency.
- Exposes writable control registers to fabric and samples read-only status inputs.
- Used as the standard DRP endpoint for bring-up and as the bench responder for axi2drp.

Parameters:
- C_DRP_ADDR_WIDTH, 12, DRP address width.
- C_DRP_DATA_WIDTH, 16, DRP data width.
- C_REG_NUM, 16, number of implemented registers (addresses 0..C_REG_NUM-1).
- C_RO_BASE, 12, first read-only register index. Registers C_RO_BASE..C_REG_NUM-1 mirror STATUS_IN. Must be less than or equal to C_REG_NUM.
- C_RDY_LATENCY, 3, cycles from accepted S_DRPEN to S_DRPRDY. Legal range 1..15.
- C_RST_VAL, 16'h0000, reset value of every RW register.

Ports:
- S_DRPCLK  in  1  DRP clock; the only clock.
- S_DRPRSTN  in  1  asynchronous active-low reset.
- S_DRPEN  in  1  transaction request, 1-cycle pulse.
- S_DRPWE  in  1  1 = write, 0 = read; qualified by S_DRPEN.
- S_DRPADDR  in  C_DRP_ADDR_WIDTH  register address.
- S_DRPDI  in  C_DRP_DATA_WIDTH  write data.
- S_DRPRDY  out  1  completion pulse.
- S_DRPDO  out  C_DRP_DATA_WIDTH  read data, valid only while S_DRPRDY = 1.
- REG_OUT  out  C_RO_BASE*C_DRP_DATA_WIDTH  flattened RW registers; reg i occupies bits [i*W +: W].
- STATUS_IN  in  (C_REG_NUM-C_RO_BASE)*C_DRP_DATA_WIDTH  flattened RO status words.
- WR_PULSE  out  C_RO_BASE  1-cycle strobe per RW register, high in the cycle its new value first appears on REG_OUT.
- ERR_CNT  out  8  saturating protocol-violation counter.

Behaviour:
- Interface: one clock, S_DRPCLK. Reset S_DRPRSTN is asynchronous, active-low.
- Reset values: S_DRPRDY=0, S_DRPDO=0, REG_OUT=C_RST_VAL per register, WR_PULSE=0, ERR_CNT=0, FSM=IDLE.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - S_DRPEN=1 latches addr, we and di.
  - Loads down-counter with C_RDY_LATENCY-1.
  - Moves to BUSY.
- BUSY:
  - Counter decrements each cycle.
  - When the counter is 0, in that cycle: drive S_DRPRDY=1, perform the access, return to IDLE.
- Timing: S_DRPEN sampled high at edge t gives S_DRPRDY high only in cycle t+C_RDY_LATENCY. With latency 1, RDY appears in the very next cycle.
- Write, in the RDY cycle:
  - addr < C_RO_BASE: register updated; visible on REG_OUT and WR_PULSE[addr] in the cycle after RDY.
  - addr >= C_RO_BASE: no state change; RDY still given.
- Read, in the RDY cycle:
  - addr < C_RO_BASE: S_DRPDO = register.
  - C_RO_BASE <= addr < C_REG_NUM: S_DRPDO = STATUS_IN word, sampled combinationally in the RDY cycle.
  - addr >= C_REG_NUM: S_DRPDO = 16'hDEAD. A write to such an address is dropped but still acknowledged.
- S_DRPDO is 0 in every cycle that RDY is 0.
- Upper address bits beyond clog2(C_REG_NUM) are compared, never truncated, so aliasing is impossible.
- S_DRPEN while BUSY, including the RDY cycle, is a violation:
  - the request is ignored;
  - ERR_CNT increments and saturates at 8'hFF;
  - the in-flight transaction completes unaffected.
- S_DRPWE, S_DRPADDR and S_DRPDI are don't-care when S_DRPEN=0.
- Reset asserted mid-transaction: the pending access is abandoned, no RDY is ever issued, all registers return to reset values immediately.

Optional Feature:
- Macro: DRP_ACCESS_CNT_EN.
- Defined: two extra RO-style registers at addresses C_REG_NUM and C_REG_NUM+1.
  - WR_COUNT and RD_COUNT, 16-bit, wrapping.
  - Each increments in the RDY cycle of every completed write or read, including dropped ones.
  - A DRP write to either address clears that counter to 0; the clearing access itself is not counted.
  - Reads of these addresses return the counter value, not 16'hDEAD.
- Undefined: no counters; those addresses read 16'hDEAD like any other out-of-range address.

Decomposition:
- Package drp_pkg holds:
  - DRP_BAD_ADDR_DATA = 16'hDEAD;
  - the FSM state enum {IDLE, BUSY};
  - ERR_CNT_WIDTH = 8;
  - shared latency-range limits.
- One sub-module, drp_rdy_timer: a loadable down-counter that produces the done strobe. It is reused by other DRP endpoints.
- The register array and address decode stay in the top module.

Test Plan:
- Write 16'h5A5A to addr 0x004 (C_RDY_LATENCY=3) -> RDY exactly 3 cycles after EN; REG_OUT word 4 = 0x5A5A one cycle later; WR_PULSE[4] pulses once.
- Read addr 0x004 after that write -> RDY at t+3 with S_DRPDO=0x5A5A; DO=0 before and after.
- Drive STATUS_IN word 0 = 0xFFEE, read addr 0x00C -> DO=0xFFEE. Write 0x1234 to 0x00C -> RDY given, subsequent read still 0xFFEE.
- Read addr 0x008 followed by a second EN 1 cycle later -> one RDY only, DO = reg 8; ERR_CNT=1. Inject 300 overlaps -> ERR_CNT=0xFF.
- Read addr 0x010 and 0xFFF -> DO=0xDEAD both. With DRP_ACCESS_CNT_EN, addr 0x010 instead returns the write count (e.g. 0x0002 after two writes).
- Deassert S_DRPRSTN one cycle after EN -> no RDY ever; REG_OUT=C_RST_VAL; a new EN after reset release completes normally with latency 3.

Source files
------------

// File: rtl/drp_pkg.sv
// Shared definitions for the DRP register endpoint: FSM states, widths,
// latency limits and small arithmetic helpers.
package drp_pkg;

  localparam logic [15:0] DRP_BAD_ADDR_DATA = 16'hDEAD;
  localparam int          ERR_CNT_WIDTH     = 8;
  localparam int          RDY_LAT_MIN       = 1;
  localparam int          RDY_LAT_MAX       = 15;
  localparam int          RDY_CNT_WIDTH     = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } drp_state_e;

  // Out-of-range latencies are clamped so the counter load value always fits.
  function automatic logic [RDY_CNT_WIDTH-1:0] lat_load_val(input int lat);
    int v;
    if (lat < RDY_LAT_MIN) begin
      v = RDY_LAT_MIN;
    end else if (lat > RDY_LAT_MAX) begin
      v = RDY_LAT_MAX;
    end else begin
      v = lat;
    end
    return RDY_CNT_WIDTH'(v - 1);
  endfunction

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    if (v == {ERR_CNT_WIDTH{1'b1}}) begin
      return v;
    end else begin
      return v + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/drp_reg_slave_if.sv
// DRP request/response bundle between a DRP master (e.g. axi2drp) and an endpoint.
interface drp_reg_slave_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          drpen;
  logic          drpwe;
  logic [AW-1:0] drpaddr;
  logic [DW-1:0] drpdi;
  logic          drprdy;
  logic [DW-1:0] drpdo;

  modport master (
    output drpen, drpwe, drpaddr, drpdi,
    input  drprdy, drpdo
  );

  modport slave (
    input  drpen, drpwe, drpaddr, drpdi,
    output drprdy, drpdo
  );
endinterface

// File: rtl/drp_rdy_timer.sv
// Loadable down-counter; o_zero flags the cycle in which the terminal count is reached.
module drp_rdy_timer #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_load_val,
  input  logic                 i_dec,
  output logic                 o_zero
);

  logic [CNT_WIDTH-1:0] r_cnt;

  // Counter register: load has priority, decrement stops at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {CNT_WIDTH{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {CNT_WIDTH{1'b0}})) begin
      r_cnt <= r_cnt - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {CNT_WIDTH{1'b0}});

endmodule

// File: rtl/drp_reg_slave.sv
// DRP register bank endpoint: RW control registers, RO status mirrors, fixed-latency RDY.
// Optional macro DRP_ACCESS_CNT_EN adds WR_COUNT/RD_COUNT at addresses C_REG_NUM and C_REG_NUM+1.
module drp_reg_slave
  import drp_pkg::*;
#(
  parameter int                          C_DRP_ADDR_WIDTH = 12,
  parameter int                          C_DRP_DATA_WIDTH = 16,
  parameter int                          C_REG_NUM        = 16,
  parameter int                          C_RO_BASE        = 12,
  parameter int                          C_RDY_LATENCY    = 3,
  parameter logic [C_DRP_DATA_WIDTH-1:0] C_RST_VAL        = 16'h0000
) (
  input  logic                                              S_DRPCLK,
  input  logic                                              S_DRPRSTN,
  drp_reg_slave_if.slave                                    s_drp,
  output logic [C_RO_BASE*C_DRP_DATA_WIDTH-1:0]             REG_OUT,
  input  logic [(C_REG_NUM-C_RO_BASE)*C_DRP_DATA_WIDTH-1:0] STATUS_IN,
  output logic [C_RO_BASE-1:0]                              WR_PULSE,
  output logic [ERR_CNT_WIDTH-1:0]                          ERR_CNT
);

  localparam int DW         = C_DRP_DATA_WIDTH;
  localparam int STATUS_NUM = C_REG_NUM - C_RO_BASE;

  drp_state_e            r_state;
  drp_state_e            w_state_nxt;
  logic                  w_accept;
  logic                  w_rdy;
  logic                  w_violation;
  logic                  w_cnt_zero;
  logic                  r_we;
  logic [C_DRP_ADDR_WIDTH-1:0] r_addr;
  logic [DW-1:0]         r_di;
  logic [31:0]           w_addr_ext;
  logic [DW-1:0]         r_regs [C_RO_BASE];
  logic [C_RO_BASE-1:0]  r_wr_pulse;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic [DW-1:0]         w_rd_data;

`ifdef DRP_ACCESS_CNT_EN
  localparam logic [DW-1:0] CNT_ONE = {{(DW-1){1'b0}}, 1'b1};
  logic [DW-1:0] r_wr_cnt;
  logic [DW-1:0] r_rd_cnt;
`endif

  // Full-width address so out-of-range addresses can never alias onto a register.
  assign w_addr_ext = 32'(r_addr);

  // State register.
  always_ff @(posedge S_DRPCLK or negedge S_DRPRSTN) begin
    if (!S_DRPRSTN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rdy       = 1'b0;
    w_violation = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_drp.drpen) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        w_violation = s_drp.drpen;
        if (w_cnt_zero) begin
          w_rdy       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  drp_rdy_timer #(
    .CNT_WIDTH (RDY_CNT_WIDTH)
  ) u_rdy_timer (
    .i_clk      (S_DRPCLK),
    .i_rst_n    (S_DRPRSTN),
    .i_load     (w_accept),
    .i_load_val (lat_load_val(C_RDY_LATENCY)),
    .i_dec      (r_state == BUSY),
    .o_zero     (w_cnt_zero)
  );

  // Request capture; requests arriving while busy never reach these registers.
  always_ff @(posedge S_DRPCLK or negedge S_DRPRSTN) begin
    if (!S_DRPRSTN) begin
      r_we   <= 1'b0;
      r_addr <= {C_DRP_ADDR_WIDTH{1'b0}};
      r_di   <= {DW{1'b0}};
    end else if (w_accept) begin
      r_we   <= s_drp.drpwe;
      r_addr <= s_drp.drpaddr;
      r_di   <= s_drp.drpdi;
    end else begin
      r_we   <= r_we;
      r_addr <= r_addr;
      r_di   <= r_di;
    end
  end

  // Protocol-violation counter.
  always_ff @(posedge S_DRPCLK or negedge S_DRPRSTN) begin
    if (!S_DRPRSTN) begin
      r_err_cnt <= {ERR_CNT_WIDTH{1'b0}};
    end else if (w_violation) begin
      r_err_cnt <= sat_inc(r_err_cnt);
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  // RW register array and write strobes, committed at the end of the RDY cycle.
  always_ff @(posedge S_DRPCLK or negedge S_DRPRSTN) begin
    if (!S_DRPRSTN) begin
      for (int i = 0; i < C_RO_BASE; i++) begin
        r_regs[i] <= C_RST_VAL;
      end
      r_wr_pulse <= {C_RO_BASE{1'b0}};
    end else begin
      for (int i = 0; i < C_RO_BASE; i++) begin
        if (w_rdy && r_we && (w_addr_ext == 32'(i))) begin
          r_regs[i]     <= r_di;
          r_wr_pulse[i] <= 1'b1;
        end else begin
          r_regs[i]     <= r_regs[i];
          r_wr_pulse[i] <= 1'b0;
        end
      end
    end
  end

`ifdef DRP_ACCESS_CNT_EN
  // Access counters; a write to a counter address clears it and is not itself counted.
  always_ff @(posedge S_DRPCLK or negedge S_DRPRSTN) begin
    if (!S_DRPRSTN) begin
      r_wr_cnt <= {DW{1'b0}};
      r_rd_cnt <= {DW{1'b0}};
    end else if (w_rdy && r_we) begin
      if (w_addr_ext == 32'(C_REG_NUM)) begin
        r_wr_cnt <= {DW{1'b0}};
      end else if (w_addr_ext == 32'(C_REG_NUM + 1)) begin
        r_rd_cnt <= {DW{1'b0}};
      end else begin
        r_wr_cnt <= r_wr_cnt + CNT_ONE;
      end
    end else if (w_rdy) begin
      r_rd_cnt <= r_rd_cnt + CNT_ONE;
    end else begin
      r_wr_cnt <= r_wr_cnt;
      r_rd_cnt <= r_rd_cnt;
    end
  end
`endif

  // Read data mux; anything unmapped returns the bad-address marker.
  always_comb begin
    w_rd_data = DW'(DRP_BAD_ADDR_DATA);
    for (int i = 0; i < C_RO_BASE; i++) begin
      if (w_addr_ext == 32'(i)) begin
        w_rd_data = r_regs[i];
      end else begin
        w_rd_data = w_rd_data;
      end
    end
    for (int k = 0; k < STATUS_NUM; k++) begin
      if (w_addr_ext == 32'(C_RO_BASE + k)) begin
        w_rd_data = STATUS_IN[k*DW +: DW];
      end else begin
        w_rd_data = w_rd_data;
      end
    end
`ifdef DRP_ACCESS_CNT_EN
    if (w_addr_ext == 32'(C_REG_NUM)) begin
      w_rd_data = r_wr_cnt;
    end else if (w_addr_ext == 32'(C_REG_NUM + 1)) begin
      w_rd_data = r_rd_cnt;
    end else begin
      w_rd_data = w_rd_data;
    end
`endif
  end

  assign s_drp.drprdy = w_rdy;
  assign s_drp.drpdo  = w_rdy ? w_rd_data : {DW{1'b0}};

  for (genvar g = 0; g < C_RO_BASE; g++) begin : g_reg_out
    assign REG_OUT[g*DW +: DW] = r_regs[g];
  end

  assign WR_PULSE = r_wr_pulse;
  assign ERR_CNT  = r_err_cnt;

endmodule

// File: tb/tb_drp_reg_slave.sv
// Self-checking bench for drp_reg_slave: directed scenarios plus randomized traffic
// checked against an array-based reference model (honours DRP_ACCESS_CNT_EN).
module tb_drp_reg_slave;

  localparam int LAT    = 3;
  localparam int NREG   = 16;
  localparam int ROB    = 12;
  localparam int WIN    = 8;

  logic                 clk;
  logic                 rst_n;
  logic [ROB*16-1:0]    reg_out;
  logic [(NREG-ROB)*16-1:0] status_in;
  logic [ROB-1:0]       wr_pulse;
  logic [7:0]           err_cnt;

  int total;
  int bad;

  drp_reg_slave_if #(.AW(12), .DW(16)) drp ();

  drp_reg_slave #(
    .C_DRP_ADDR_WIDTH (12),
    .C_DRP_DATA_WIDTH (16),
    .C_REG_NUM        (NREG),
    .C_RO_BASE        (ROB),
    .C_RDY_LATENCY    (LAT),
    .C_RST_VAL        (16'h0000)
  ) dut (
    .S_DRPCLK  (clk),
    .S_DRPRSTN (rst_n),
    .s_drp     (drp),
    .REG_OUT   (reg_out),
    .STATUS_IN (status_in),
    .WR_PULSE  (wr_pulse),
    .ERR_CNT   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_regs [ROB];
  logic [15:0] m_status [NREG-ROB];
  int          m_err;
  logic [15:0] m_wr_cnt;
  logic [15:0] m_rd_cnt;

  // Per-transaction observations, index k = cycles after the EN edge
  logic             obs_rdy    [1:WIN];
  logic [15:0]      obs_do     [1:WIN];
  logic [ROB-1:0]   obs_pulse  [1:WIN];
  logic [ROB*16-1:0] obs_regout [1:WIN];
  logic [7:0]       obs_err    [1:WIN];
  int               rdy_first, rdy_cnt, do_leak, pulse_total, pulse_cycle;
  logic [15:0]      rdy_do;
  logic [ROB-1:0]   pulse_vec;

  function automatic logic [15:0] model_read(input logic [11:0] a);
    int ai;
    ai = int'(a);
    if (ai < ROB) return m_regs[ai];
    if (ai < NREG) return m_status[ai-ROB];
`ifdef DRP_ACCESS_CNT_EN
    if (ai == NREG) return m_wr_cnt;
    if (ai == NREG + 1) return m_rd_cnt;
`endif
    return 16'hDEAD;
  endfunction

  task automatic model_commit(input logic we, input logic [11:0] a, input logic [15:0] di);
    int ai;
    ai = int'(a);
    if (we) begin
      if (ai < ROB) m_regs[ai] = di;
`ifdef DRP_ACCESS_CNT_EN
      if (ai == NREG) m_wr_cnt = 16'h0000;
      else if (ai == NREG + 1) m_rd_cnt = 16'h0000;
      else m_wr_cnt = m_wr_cnt + 16'h0001;
`endif
    end else begin
`ifdef DRP_ACCESS_CNT_EN
      m_rd_cnt = m_rd_cnt + 16'h0001;
`endif
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ROB; i++) m_regs[i] = 16'h0000;
    m_err    = 0;
    m_wr_cnt = 16'h0000;
    m_rd_cnt = 16'h0000;
  endtask

  function automatic logic [ROB*16-1:0] model_regout();
    logic [ROB*16-1:0] v;
    for (int i = 0; i < ROB; i++) v[i*16 +: 16] = m_regs[i];
    return v;
  endfunction

  task automatic drive_status();
    for (int i = 0; i < NREG-ROB; i++) status_in[i*16 +: 16] = m_status[i];
  endtask

  // Issue one request and watch WIN cycles; optionally a second EN (dup_at) or reset (rst_at).
  task automatic run_txn(input logic we, input logic [11:0] a, input logic [15:0] di,
                         input int dup_at, input int rst_at);
    @(negedge clk);
    drp.drpen = 1'b1; drp.drpwe = we; drp.drpaddr = a; drp.drpdi = di;
    rdy_first = -1; rdy_cnt = 0; do_leak = 0; rdy_do = 16'h0000;
    pulse_total = 0; pulse_cycle = -1; pulse_vec = '0;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      obs_rdy[k] = drp.drprdy; obs_do[k] = drp.drpdo; obs_pulse[k] = wr_pulse;
      obs_regout[k] = reg_out; obs_err[k] = err_cnt;
      if (obs_rdy[k] === 1'b1) begin
        rdy_cnt++;
        if (rdy_first < 0) begin rdy_first = k; rdy_do = obs_do[k]; end
      end else if (obs_do[k] !== 16'h0000) begin
        do_leak++;
      end
      pulse_total += $countones(obs_pulse[k]);
      if (pulse_cycle < 0 && obs_pulse[k] != '0) begin
        pulse_cycle = k; pulse_vec = obs_pulse[k];
      end
      if (k == dup_at) begin
        drp.drpen = 1'b1; drp.drpwe = 1'($urandom); drp.drpaddr = 12'($urandom);
        drp.drpdi = 16'($urandom);
      end else begin
        drp.drpen = 1'b0; drp.drpwe = 1'($urandom); drp.drpaddr = 12'($urandom);
        drp.drpdi = 16'($urandom);
      end
      if (k == rst_at) rst_n = 1'b0;
    end
  endtask

  task automatic test_reset();
    total++;
    if (drp.drprdy !== 1'b0 || drp.drpdo !== 16'h0000) begin
      bad++; $display("FAIL reset_rdy_do: got rdy=%b do=%h, want 0/0000", drp.drprdy, drp.drpdo);
    end
    total++;
    if (reg_out !== '0 || wr_pulse !== '0 || err_cnt !== 8'h00) begin
      bad++; $display("FAIL reset_state: got regout=%h pulse=%h err=%h, want zeros", reg_out, wr_pulse, err_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (drp.drprdy !== 1'b0 || err_cnt !== 8'h00) begin
      bad++; $display("FAIL reset_release: got rdy=%b err=%h, want 0/00", drp.drprdy, err_cnt);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] old4;
    old4 = m_regs[4];
    run_txn(1'b1, 12'h004, 16'h5A5A, 0, 0);
    model_commit(1'b1, 12'h004, 16'h5A5A);
    total++;
    if (rdy_first != LAT || rdy_cnt != 1) begin
      bad++; $display("FAIL wr_latency: got first=%0d cnt=%0d, want %0d/1", rdy_first, rdy_cnt, LAT);
    end
    total++;
    if (obs_regout[LAT][4*16 +: 16] !== old4 || obs_regout[LAT+1][4*16 +: 16] !== 16'h5A5A) begin
      bad++; $display("FAIL wr_regout: got %h then %h, want %h then 5a5a",
                      obs_regout[LAT][4*16 +: 16], obs_regout[LAT+1][4*16 +: 16], old4);
    end
    total++;
    if (pulse_total != 1 || pulse_cycle != LAT+1 || pulse_vec !== 12'h010) begin
      bad++; $display("FAIL wr_pulse: got total=%0d cyc=%0d vec=%h, want 1/%0d/010",
                      pulse_total, pulse_cycle, pulse_vec, LAT+1);
    end
    run_txn(1'b0, 12'h004, 16'h0000, 0, 0);
    model_commit(1'b0, 12'h004, 16'h0000);
    total++;
    if (rdy_first != LAT || rdy_do !== 16'h5A5A || do_leak != 0) begin
      bad++; $display("FAIL rd_reg4: got first=%0d do=%h leak=%0d, want %0d/5a5a/0", rdy_first, rdy_do, do_leak, LAT);
    end
  endtask

  task automatic test_status();
    m_status[0] = 16'hFFEE; drive_status();
    run_txn(1'b0, 12'h00C, 16'h0000, 0, 0);
    model_commit(1'b0, 12'h00C, 16'h0000);
    total++;
    if (rdy_do !== 16'hFFEE) begin
      bad++; $display("FAIL rd_status: got %h, want ffee", rdy_do);
    end
    run_txn(1'b1, 12'h00C, 16'h1234, 0, 0);
    model_commit(1'b1, 12'h00C, 16'h1234);
    total++;
    if (rdy_first != LAT || rdy_cnt != 1 || pulse_total != 0 || obs_regout[WIN] !== model_regout()) begin
      bad++; $display("FAIL wr_status: got first=%0d cnt=%0d pulses=%0d, want %0d/1/0", rdy_first, rdy_cnt, pulse_total, LAT);
    end
    run_txn(1'b0, 12'h00C, 16'h0000, 0, 0);
    model_commit(1'b0, 12'h00C, 16'h0000);
    total++;
    if (rdy_do !== 16'hFFEE) begin
      bad++; $display("FAIL rd_status_after_wr: got %h, want ffee", rdy_do);
    end
  endtask

  task automatic test_bad_addr();
`ifdef DRP_ACCESS_CNT_EN
    run_txn(1'b1, 12'h010, 16'hFFFF, 0, 0);
    model_commit(1'b1, 12'h010, 16'hFFFF);
    run_txn(1'b1, 12'h001, 16'h1111, 0, 0);
    model_commit(1'b1, 12'h001, 16'h1111);
    run_txn(1'b1, 12'h7FF, 16'h2222, 0, 0);
    model_commit(1'b1, 12'h7FF, 16'h2222);
    run_txn(1'b0, 12'h010, 16'h0000, 0, 0);
    model_commit(1'b0, 12'h010, 16'h0000);
    total++;
    if (rdy_do !== 16'h0002) begin
      bad++; $display("FAIL rd_wr_count: got %h, want 0002", rdy_do);
    end
`else
    run_txn(1'b0, 12'h010, 16'h0000, 0, 0);
    model_commit(1'b0, 12'h010, 16'h0000);
    total++;
    if (rdy_do !== 16'hDEAD || rdy_first != LAT) begin
      bad++; $display("FAIL rd_addr_010: got %h at %0d, want dead at %0d", rdy_do, rdy_first, LAT);
    end
`endif
    run_txn(1'b0, 12'hFFF, 16'h0000, 0, 0);
    model_commit(1'b0, 12'hFFF, 16'h0000);
    total++;
    if (rdy_do !== 16'hDEAD || rdy_first != LAT) begin
      bad++; $display("FAIL rd_addr_fff: got %h at %0d, want dead at %0d", rdy_do, rdy_first, LAT);
    end
    run_txn(1'b1, 12'h804, 16'hBEEF, 0, 0);
    model_commit(1'b1, 12'h804, 16'hBEEF);
    total++;
    if (rdy_cnt != 1 || pulse_total != 0 || obs_regout[WIN] !== model_regout()) begin
      bad++; $display("FAIL wr_alias_804: got cnt=%0d pulses=%0d regout=%h, want 1/0/%h",
                      rdy_cnt, pulse_total, obs_regout[WIN], model_regout());
    end
  endtask

  task automatic test_overlap();
    logic [15:0] exp;
    run_txn(1'b1, 12'h008, 16'hC3A5, 0, 0);
    model_commit(1'b1, 12'h008, 16'hC3A5);
    exp = model_read(12'h008);
    run_txn(1'b0, 12'h008, 16'h0000, 1, 0);
    model_commit(1'b0, 12'h008, 16'h0000);
    m_err = (m_err < 255) ? m_err + 1 : 255;
    total++;
    if (rdy_cnt != 1 || rdy_first != LAT || rdy_do !== exp) begin
      bad++; $display("FAIL overlap_txn: got cnt=%0d first=%0d do=%h, want 1/%0d/%h", rdy_cnt, rdy_first, rdy_do, LAT, exp);
    end
    total++;
    if (int'(obs_err[WIN]) != m_err || obs_regout[WIN] !== model_regout()) begin
      bad++; $display("FAIL overlap_err1: got err=%0d, want %0d", obs_err[WIN], m_err);
    end
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [11:0] a;
      logic [15:0] di;
      we = 1'($urandom); a = 12'($urandom_range(0, 19)); di = 16'($urandom);
      exp = model_read(a);
      run_txn(we, a, di, $urandom_range(1, LAT), 0);
      model_commit(we, a, di);
      m_err = (m_err < 255) ? m_err + 1 : 255;
      total++;
      if (rdy_cnt != 1 || int'(obs_err[WIN]) != m_err || (!we && rdy_do !== exp)) begin
        bad++; $display("FAIL overlap_loop[%0d]: got cnt=%0d err=%0d do=%h, want 1/%0d/%h",
                        n, rdy_cnt, obs_err[WIN], rdy_do, m_err, exp);
      end
    end
    total++;
    if (err_cnt !== 8'hFF) begin
      bad++; $display("FAIL err_saturate: got %h, want ff", err_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic        we;
      logic [11:0] a;
      logic [15:0] di;
      logic [15:0] exp;
      logic [ROB-1:0] exp_vec;
      for (int i = 0; i < NREG-ROB; i++) m_status[i] = 16'($urandom);
      drive_status();
      we = 1'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 19));
      di = 16'($urandom);
      exp = model_read(a);
      run_txn(we, a, di, 0, 0);
      model_commit(we, a, di);
      total++;
      if (rdy_first != LAT || rdy_cnt != 1 || do_leak != 0) begin
        bad++; $display("FAIL rnd_handshake[%0d]: got first=%0d cnt=%0d leak=%0d, want %0d/1/0",
                        n, rdy_first, rdy_cnt, do_leak, LAT);
      end
      if (!we) begin
        total++;
        if (rdy_do !== exp) begin
          bad++; $display("FAIL rnd_read[%0d] addr=%h: got %h, want %h", n, a, rdy_do, exp);
        end
      end
      exp_vec = '0;
      if (we && int'(a) < ROB) exp_vec[a] = 1'b1;
      total++;
      if (pulse_total != $countones(exp_vec) || pulse_vec !== exp_vec ||
          (exp_vec != '0 && pulse_cycle != LAT+1)) begin
        bad++; $display("FAIL rnd_pulse[%0d]: got vec=%h total=%0d cyc=%0d, want vec=%h",
                        n, pulse_vec, pulse_total, pulse_cycle, exp_vec);
      end
      total++;
      if (obs_regout[WIN] !== model_regout() || int'(obs_err[WIN]) != m_err) begin
        bad++; $display("FAIL rnd_state[%0d]: got regout=%h err=%0d, want %h/%0d",
                        n, obs_regout[WIN], obs_err[WIN], model_regout(), m_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_txn(1'b1, 12'h005, 16'h7E57, 0, 1);
    model_reset();
    total++;
    if (rdy_cnt != 0) begin
      bad++; $display("FAIL rst_mid_rdy: got %0d rdy pulses, want 0", rdy_cnt);
    end
    total++;
    if (obs_regout[WIN] !== '0 || obs_err[WIN] !== 8'h00) begin
      bad++; $display("FAIL rst_mid_state: got regout=%h err=%h, want zeros", obs_regout[WIN], obs_err[WIN]);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(1'b1, 12'h005, 16'h0BAD, 0, 0);
    model_commit(1'b1, 12'h005, 16'h0BAD);
    total++;
    if (rdy_first != LAT || rdy_cnt != 1 || obs_regout[WIN] !== model_regout()) begin
      bad++; $display("FAIL rst_recover: got first=%0d cnt=%0d, want %0d/1", rdy_first, rdy_cnt, LAT);
    end
    run_txn(1'b0, 12'h003, 16'h0000, 0, 0);
    model_commit(1'b0, 12'h003, 16'h0000);
    total++;
    if (rdy_do !== 16'h0000 || rdy_first != LAT) begin
      bad++; $display("FAIL rst_regs_cleared: got %h, want 0000", rdy_do);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    drp.drpen = 1'b0; drp.drpwe = 1'b0; drp.drpaddr = 12'h000; drp.drpdi = 16'h0000;
    for (int i = 0; i < NREG-ROB; i++) m_status[i] = 16'h0000;
    drive_status();
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_write_read();
    test_status();
    test_bad_addr();
    test_overlap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
